mip_irq_ctrl: RTL and testbench
===============================

// Module: mip_irq_ctrl
// PURPOSE
//  Parametrised machine-interrupt-pending controller; next generation of the single-bit MIP block.
//  Takes N_IRQ external sources, a timer source and a software source.
//  Synchronises every input and supports per-source level/edge mode, enable masking and
//  fixed priority. Adds a claim/complete handshake.
//  Drives MEIP/MTIP/MSIP to the CSR file and trap logic, plus the 32-bit MIP read image.
// PARAMETERS
//  N_IRQ        8   number of external sources, 1..31; source i has ID i+1, ID 0 = none
//  SYNC_STAGES  2   synchroniser flops per async input, 0..3 (0 = inputs already synchronous)
//  EDGE_MASK    0   N_IRQ-bit mask; bit i=1 -> source i rising-edge, 0 -> level
//  (localparam IDW = $clog2(N_IRQ+1), width of IDs)
// PORTS
//  clk_in          in   1      clock
//  rst_n_in        in   1      reset, synchronous, active-low
//  irq_src_in      in   N_IRQ  external interrupt sources, async
//  t_irq_in        in   1      timer interrupt, async
//  s_irq_in        in   1      software interrupt, async
//  en_wr_in        in   1      write strobe for enable mask
//  en_wdata_in     in   N_IRQ  new enable mask
//  claim_in        in   1      claim request (single-cycle pulse expected)
//  complete_in     in   1      completion strobe
//  complete_id_in  in   IDW    ID being completed
//  meip_out        out  1      external interrupt pending (any eligible source)
//  mtip_out        out  1      timer pending
//  msip_out        out  1      software pending
//  claim_valid_out out  1      claim response valid, one-cycle pulse
//  claim_id_out    out  IDW    claimed ID (0 = nothing eligible)
//  pending_out     out  N_IRQ  raw pending vector
//  en_out          out  N_IRQ  current enable mask
//  mip_reg_out     out  32     {20'b0,meip,3'b0,mtip,3'b0,msip,3'b0}
// BEHAVIOUR
//  Reset (rst_n_in low at a rising edge): every flop clears.
//   Includes synchronisers, pending, in_service, enable, FSM (IDLE); all outputs 0.
//  Sync: each input passes SYNC_STAGES flops. s_i = synchronised value.
//   Edge detect uses a registered copy of s_i.
//  Pending[i], level: pending <= s_i every cycle.
//  Pending[i], edge: set on s_i & ~s_i_d; cleared when ID i+1 is claimed.
//   Set wins over clear in the same cycle, so no edge is lost.
//  Edges are captured while disabled or in service.
//  Latency: input high at sampling edge 1 -> pending after edge SYNC_STAGES+1.
//   meip_out follows after edge SYNC_STAGES+2.
//   mtip_out/msip_out = registered s_t/s_s, after edge SYNC_STAGES+1.
//  Enable: en <= en_wdata_in on en_wr_in; effective for eligibility next cycle.
//  eligible = pending & en & ~in_service. meip_out <= |eligible (registered).
//  Priority: lowest index wins (source 0 highest).
//  FSM IDLE/RESP.
//   IDLE + claim_in at edge k: after edge k, claim_valid_out=1, claim_id_out = winner ID or 0.
//    Same edge: in_service[winner] set, edge-mode pending[winner] cleared; FSM -> RESP.
//   RESP: claim_in ignored; after next edge valid=0, id=0, FSM -> IDLE.
//   Max one claim per 2 cycles.
//  Complete: complete_in with in-service ID clears in_service[id-1] at that edge.
//   ID 0, out-of-range or not-in-service IDs are ignored.
//   Claim and complete in the same cycle: both applied.
//   Completing the winner in its own claim cycle is ignored, because it is not yet in service.
//  Level source with pending still high after complete: re-eligible next cycle.
//  Reset mid-claim: response pulse aborted, claim_valid_out 0 after the reset edge.
// TESTING
//  1 Reset: hold rst_n_in=0 3 cycles with all inputs high -> every output 0, mip_reg_out=0.
//  2 Latency, SYNC_STAGES=2: t_irq_in 0->1 -> mtip_out=1 after edge 3, mip_reg_out=32'h80.
//    Same for s_irq_in -> msip_out=1 after edge 3, mip_reg_out=32'h08.
//  3 Priority, en=8'hFF: level sources 2,5 high, claim -> id 3 valid 1 cycle.
//    Second claim -> id 6; third claim -> id 0 with meip_out=0.
//  4 Edge mode, EDGE_MASK=8'h01: 1-cycle pulse on src0 -> pending_out[0]=1 until claim(id 1).
//    New edge landing on claim cycle -> pending_out[0] stays 1.
//  5 Complete: complete_id_in=1 -> level src0 still high -> meip_out=1 again.
//    complete_id_in=7 (not in service) -> no state change.
//  6 Masking: en=0 with src4 pending -> meip_out=0, claim id 0.
//    Write en=8'h10 -> meip_out=1 two cycles later; claim_in during RESP ignored.

Source files
------------

// File: rtl/mip_irq_ctrl.sv
// mip_irq_ctrl: machine interrupt pending controller with sync, edge/level, masking, priority and claim/complete
module mip_irq_ctrl #(
  parameter int               N_IRQ       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [N_IRQ-1:0]           irq_src_in,
  input  logic                       t_irq_in,
  input  logic                       s_irq_in,
  input  logic                       en_wr_in,
  input  logic [N_IRQ-1:0]           en_wdata_in,
  input  logic                       claim_in,
  input  logic                       complete_in,
  input  logic [$clog2(N_IRQ+1)-1:0] complete_id_in,
  output logic                       meip_out,
  output logic                       mtip_out,
  output logic                       msip_out,
  output logic                       claim_valid_out,
  output logic [$clog2(N_IRQ+1)-1:0] claim_id_out,
  output logic [N_IRQ-1:0]           pending_out,
  output logic [N_IRQ-1:0]           en_out,
  output logic [31:0]                mip_reg_out
);
  localparam int IDW = $clog2(N_IRQ+1);
  localparam int W   = N_IRQ + 2;
  typedef enum logic {IDLE, RESP} state_t;
  state_t             state_q, state_d;
  logic [W-1:0]       raw, s;
  logic [N_IRQ-1:0]   s_ext, s_d_q, pend_q, pend_d, en_q, en_d, insvc_q, insvc_d;
  logic [N_IRQ-1:0]   elig, claim_m, cmp_m;
  logic [IDW-1:0]     win_id, id_q, id_d;
  logic               meip_q, mtip_q, msip_q, valid_q, valid_d, accept;
  assign raw   = {s_irq_in, t_irq_in, irq_src_in};
  assign s_ext = s[N_IRQ-1:0];
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = raw;
    end else begin : g_sync
      logic [W-1:0] sync_q [SYNC_STAGES];
      // shift every asynchronous input through its synchroniser chain
      always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= raw;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  assign elig = pend_q & en_q & ~insvc_q;
  // lowest-index eligible source wins; ID 0 means nothing eligible
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (elig[i]) win_id = IDW'(i + 1);
  end
  // state register
  always_ff @(posedge clk_in) state_q <= !rst_n_in ? IDLE : state_d;
  // a claim in IDLE moves to RESP for exactly one cycle
  always_comb state_d = (state_q == IDLE && claim_in) ? RESP : IDLE;
  // claim acceptance and response values; claims during RESP are dropped
  always_comb begin
    accept  = (state_q == IDLE) && claim_in;
    valid_d = accept;
    id_d    = accept ? win_id : '0;
  end
  // per-source claim/complete masks and next-state for pending, service and enable
  always_comb begin
    for (int i = 0; i < N_IRQ; i++) begin
      claim_m[i] = accept && (win_id == IDW'(i + 1));
      cmp_m[i]   = complete_in && (complete_id_in == IDW'(i + 1));
    end
    pend_d  = (EDGE_MASK & ((s_ext & ~s_d_q) | (pend_q & ~claim_m))) | (~EDGE_MASK & s_ext);
    insvc_d = (insvc_q & ~cmp_m) | claim_m;
    en_d    = en_wr_in ? en_wdata_in : en_q;
  end
  // datapath registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s_d_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      insvc_q <= '0;
      meip_q  <= 1'b0;
      mtip_q  <= 1'b0;
      msip_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      s_d_q   <= s_ext;
      pend_q  <= pend_d;
      en_q    <= en_d;
      insvc_q <= insvc_d;
      meip_q  <= |elig;
      mtip_q  <= s[N_IRQ];
      msip_q  <= s[N_IRQ+1];
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end
  assign meip_out        = meip_q;
  assign mtip_out        = mtip_q;
  assign msip_out        = msip_q;
  assign claim_valid_out = valid_q;
  assign claim_id_out    = id_q;
  assign pending_out     = pend_q;
  assign en_out          = en_q;
  assign mip_reg_out     = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
endmodule

// File: tb/tb_mip_irq_ctrl.sv
// tb_mip_irq_ctrl: directed checks of a level-mode and an edge-mode (source 0) controller
module tb_mip_irq_ctrl;
  logic       clk = 0, rst_n = 0;
  logic [7:0] irq_src = 0, en_wdata = 0;
  logic       t_irq = 0, s_irq = 0, en_wr = 0, claim = 0, complete = 0;
  logic [3:0] complete_id = 0;
  logic       l_meip, l_mtip, l_msip, l_valid, e_meip, e_mtip, e_msip, e_valid;
  logic [3:0] l_id, e_id;
  logic [7:0] l_pend, l_en, e_pend, e_en;
  logic [31:0] l_mip, e_mip;
  int n = 0, errs = 0;
  always #5 clk = ~clk;
  mip_irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2), .EDGE_MASK(8'h00)) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .irq_src_in(irq_src), .t_irq_in(t_irq), .s_irq_in(s_irq),
    .en_wr_in(en_wr), .en_wdata_in(en_wdata), .claim_in(claim), .complete_in(complete),
    .complete_id_in(complete_id), .meip_out(l_meip), .mtip_out(l_mtip), .msip_out(l_msip),
    .claim_valid_out(l_valid), .claim_id_out(l_id), .pending_out(l_pend), .en_out(l_en),
    .mip_reg_out(l_mip));
  mip_irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2), .EDGE_MASK(8'h01)) dut_e (
    .clk_in(clk), .rst_n_in(rst_n), .irq_src_in(irq_src), .t_irq_in(t_irq), .s_irq_in(s_irq),
    .en_wr_in(en_wr), .en_wdata_in(en_wdata), .claim_in(claim), .complete_in(complete),
    .complete_id_in(complete_id), .meip_out(e_meip), .mtip_out(e_mtip), .msip_out(e_msip),
    .claim_valid_out(e_valid), .claim_id_out(e_id), .pending_out(e_pend), .en_out(e_en),
    .mip_reg_out(e_mip));
  task automatic tick(input int c = 1);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    irq_src = 8'hFF; t_irq = 1; s_irq = 1; en_wr = 1; en_wdata = 8'hFF;
    claim = 1; complete = 1; complete_id = 1;
    tick(3);
    chk("rst_meip", l_meip, 0); chk("rst_mtip", l_mtip, 0); chk("rst_msip", l_msip, 0);
    chk("rst_valid", l_valid, 0); chk("rst_id", l_id, 0); chk("rst_pend", l_pend, 0);
    chk("rst_en", l_en, 0); chk("rst_mip", l_mip, 0);
    irq_src = 0; t_irq = 0; s_irq = 0; en_wr = 0; en_wdata = 0; claim = 0; complete = 0; complete_id = 0;
    tick(1);
    rst_n = 1;
    t_irq = 1;
    tick(2); chk("mtip_early", l_mtip, 0);
    tick(1); chk("mtip_lat", l_mtip, 1); chk("mip_mtip", l_mip, 32'h80);
    t_irq = 0;
    tick(3); chk("mtip_off", l_mtip, 0);
    s_irq = 1;
    tick(2); chk("msip_early", l_msip, 0);
    tick(1); chk("msip_lat", l_msip, 1); chk("mip_msip", l_mip, 32'h08);
    s_irq = 0;
    tick(3);
    en_wr = 1; en_wdata = 8'hFF; tick(1); en_wr = 0;
    chk("en_ff", l_en, 8'hFF);
    irq_src = 8'h24;
    tick(3); chk("pend_24", l_pend, 8'h24); chk("meip_lag", l_meip, 0);
    tick(1); chk("meip_on", l_meip, 1);
    claim = 1; tick(1); claim = 0;
    chk("c1_valid", l_valid, 1); chk("c1_id", l_id, 3);
    tick(1); chk("c1_valid_off", l_valid, 0); chk("c1_id_off", l_id, 0);
    claim = 1; tick(1); claim = 0;
    chk("c2_id", l_id, 6);
    tick(1); chk("c2_meip_off", l_meip, 0);
    claim = 1; tick(1); claim = 0;
    chk("c3_valid", l_valid, 1); chk("c3_id", l_id, 0); chk("c3_meip", l_meip, 0);
    tick(1);
    complete = 1; complete_id = 3; tick(1); complete_id = 6; tick(1); complete = 0;
    irq_src = 0; tick(4);
    chk("drain_pend", l_pend, 0);
    irq_src = 8'h01; tick(1); irq_src = 0; tick(2);
    chk("edge_set", e_pend[0], 1);
    tick(2); chk("edge_hold", e_pend[0], 1); chk("lvl_gone", l_pend[0], 0);
    claim = 1; tick(1); claim = 0;
    chk("edge_claim_id", e_id, 1); chk("edge_clr", e_pend[0], 0);
    tick(1);
    complete = 1; complete_id = 1; tick(1); complete = 0;
    irq_src = 8'h01; tick(1); irq_src = 0; tick(3);
    chk("edge_set2", e_pend[0], 1);
    irq_src = 8'h01; tick(1); irq_src = 0; tick(1);
    claim = 1; tick(1); claim = 0;
    chk("edge_race_id", e_id, 1); chk("edge_race_pend", e_pend[0], 1);
    tick(1);
    complete = 1; complete_id = 1; tick(1); complete = 0;
    tick(1);
    claim = 1; tick(1); claim = 0;
    chk("edge_reclaim_id", e_id, 1); chk("edge_reclaim_pend", e_pend[0], 0);
    tick(1);
    complete = 1; complete_id = 1; tick(1); complete = 0;
    tick(2);
    irq_src = 8'h01; tick(4);
    chk("cmp_meip_on", l_meip, 1);
    claim = 1; tick(1); claim = 0;
    chk("cmp_claim_id", l_id, 1);
    tick(1); chk("cmp_meip_off", l_meip, 0);
    complete = 1; complete_id = 7; tick(1); complete = 0;
    chk("cmp7_meip", l_meip, 0); chk("cmp7_pend", l_pend, 8'h01);
    tick(1); chk("cmp7_meip2", l_meip, 0);
    complete = 1; complete_id = 1; tick(1); complete = 0;
    tick(1); chk("cmp1_meip", l_meip, 1);
    claim = 1; tick(1); claim = 0;
    chk("cmp1_reclaim", l_id, 1);
    tick(1);
    complete = 1; complete_id = 1; tick(1); complete = 0;
    irq_src = 0; tick(4);
    en_wr = 1; en_wdata = 8'h00; tick(1); en_wr = 0;
    irq_src = 8'h10; tick(4);
    chk("mask_pend", l_pend, 8'h10);
    tick(1); chk("mask_meip", l_meip, 0);
    claim = 1; tick(1); claim = 0;
    chk("mask_valid", l_valid, 1); chk("mask_id", l_id, 0);
    tick(1);
    en_wr = 1; en_wdata = 8'h10; tick(1); en_wr = 0;
    chk("en10", l_en, 8'h10); chk("en10_meip_lag", l_meip, 0);
    tick(1); chk("en10_meip", l_meip, 1);
    claim = 1; tick(1);
    chk("resp_id", l_id, 5);
    tick(1); claim = 0;
    chk("resp_ignored_valid", l_valid, 0); chk("resp_ignored_id", l_id, 0);
    claim = 1; tick(1); claim = 0;
    chk("insvc_id", l_id, 0); chk("insvc_valid", l_valid, 1);
    tick(1);
    complete = 1; complete_id = 5; tick(1); complete = 0;
    tick(1);
    claim = 1; tick(1); claim = 0;
    chk("pre_rst_id", l_id, 5);
    rst_n = 0; tick(1);
    chk("rst_abort_valid", l_valid, 0); chk("rst_abort_en", l_en, 0);
    rst_n = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
